biriscv_lsu_cmo_ctrl: RTL and testbench
=======================================

BIRISCV_LSU_CMO_CTRL -- requirements
Module: biriscv_lsu_cmo_ctrl

Interface
REQ-001 Parameter LINE_OFFSET_W, default 5, SHALL set the line-offset bits cleared in mem_addr_o (32-byte lines).
REQ-002 Parameter TIMEOUT_W, default 8, SHALL set the ack-timeout counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 opcode_valid_i  input  1  SHALL qualify the current LSU opcode; sole gate for command capture.
REQ-006 cmo_flush_i / cmo_writeback_i / cmo_invalidate_i  input  1 each  SHALL be the requested cache-maintenance op.
REQ-007 cmo_addr_i  input  32  SHALL be the operation address.
REQ-008 mem_accept_i  input  1  SHALL be the memory port's request accept.
REQ-009 mem_ack_i / mem_error_i  input  1 each  SHALL be the completion strobe and its error qualifier.
REQ-010 mem_flush_o / mem_writeback_o / mem_invalidate_o  output  1 each  SHALL be the registered request strobes.
REQ-011 mem_addr_o  output  32  SHALL be the registered, line-aligned request address.
REQ-012 stall_o  output  1  SHALL hold the LSU pipeline.
REQ-013 done_o / error_o  output  1 each  SHALL be the one-cycle completion pulse and its error flag.

Function
REQ-014 The block SHALL implement states IDLE, REQ, WAIT_ACK, DONE.
REQ-015 In IDLE, capture SHALL occur only when opcode_valid_i=1 and at least one cmo_*_i=1; mem_accept_i, mem_ack_i and any other input SHALL never substitute for opcode_valid_i.
REQ-016 With opcode_valid_i=0, no strobe SHALL assert and state SHALL stay IDLE, regardless of cmo_*_i or mem_accept_i.
REQ-017 Multiple cmo_*_i high SHALL resolve by priority flush > writeback > invalidate; exactly one strobe asserts.
REQ-018 On capture: next cycle state=REQ, selected strobe=1, mem_addr_o = cmo_addr_i with bits [LINE_OFFSET_W-1:0] zeroed.
REQ-019 In REQ, strobe and address SHALL hold stable until mem_accept_i=1; on accept, strobe clears next cycle.
REQ-020 REQ with mem_accept_i=1 and mem_ack_i=0 SHALL go to WAIT_ACK; with both =1 SHALL go directly to DONE.
REQ-021 The timeout counter SHALL clear on entering WAIT_ACK and increment each WAIT_ACK cycle without mem_ack_i.
REQ-022 WAIT_ACK with mem_ack_i=1 SHALL go to DONE; error_o in DONE = mem_error_i sampled with that ack.
REQ-023 Counter at 2^TIMEOUT_W-1 with no ack SHALL go to DONE with error_o=1; ack arriving that same cycle wins (error_o=mem_error_i).
REQ-024 DONE SHALL assert done_o for exactly one cycle, then return to IDLE; done_o and error_o are 0 in all other states.
REQ-025 stall_o SHALL be combinational: 1 in REQ and WAIT_ACK, and in IDLE when a capture condition (REQ-015) is present; 0 in DONE otherwise.
REQ-026 cmo_*_i inputs while not IDLE SHALL be ignored (no queuing).
REQ-027 mem_ack_i in IDLE, REQ-without-accept, or DONE SHALL be ignored with no state or output change.
REQ-028 Minimum latency SHALL be capture (cycle 0) -> strobe (cycle 1) -> accept+ack (cycle 1) -> done_o (cycle 2).

Reset
REQ-029 rst_i=1 SHALL immediately force state=IDLE, all strobes=0, mem_addr_o=0, done_o=0, error_o=0, counter=0.
REQ-030 Reset during REQ or WAIT_ACK SHALL abandon the operation with no done_o pulse; a later stray ack SHALL be ignored per REQ-027.
REQ-031 After rst_i deassertion, the first capture SHALL be possible on the first clock edge.

Verification
REQ-032 opcode_valid_i=0, cmo_writeback_i=1, mem_accept_i=1 for 10 cycles -> all strobes 0, stall_o=0, state IDLE (gating check).
REQ-033 opcode_valid_i=1, cmo_writeback_i=1, cmo_addr_i=0x8000_1234; mem_accept_i at cycle 3, ack cycle 5 -> mem_writeback_o=1 cycles 1-3, mem_addr_o=0x8000_1220, done_o=1 cycle 6, error_o=0.
REQ-034 cmo_flush_i=cmo_invalidate_i=1 with opcode_valid_i=1; accept+ack cycle 1 -> only mem_flush_o asserted, done_o at cycle 2.
REQ-035 Accepted request, no ack, TIMEOUT_W=8 -> done_o with error_o=1 after 256 WAIT_ACK cycles; repeat with ack+mem_error_i=1 -> error_o=1.
REQ-036 rst_i pulsed in WAIT_ACK, then mem_ack_i=1 -> no done_o, outputs 0, next opcode_valid_i capture proceeds normally.

Source files
------------

// File: rtl/biriscv_lsu_cmo_ctrl.sv
// rtl/biriscv_lsu_cmo_ctrl.sv - LSU cache-maintenance-operation request controller
//
// Purpose: captures one flush/writeback/invalidate request from the LSU and
// issues it as a registered strobe with a line-aligned address. It waits for
// the memory port to accept and then acknowledge the request, and reports
// completion with a one-cycle done pulse. An ack timeout completes the
// operation with an error.
//
// Ports:
//   clk, rst_i                    clock, asynchronous active-high reset
//   opcode_valid_i                qualifies the cmo_*_i request
//   cmo_flush_i/_writeback_i/_invalidate_i, cmo_addr_i   requested op + address
//   mem_accept_i                  memory port accepts the request strobe
//   mem_ack_i, mem_error_i        completion strobe and its error qualifier
//   mem_flush_o/_writeback_o/_invalidate_o, mem_addr_o   registered request
//   stall_o                       holds the LSU pipeline
//   done_o, error_o               one-cycle completion pulse and error flag

module biriscv_lsu_cmo_ctrl #(
    parameter int LINE_OFFSET_W = 5,
    parameter int TIMEOUT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        opcode_valid_i,
    input  logic        cmo_flush_i,
    input  logic        cmo_writeback_i,
    input  logic        cmo_invalidate_i,
    input  logic [31:0] cmo_addr_i,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic        mem_error_i,
    output logic        mem_flush_o,
    output logic        mem_writeback_o,
    output logic        mem_invalidate_o,
    output logic [31:0] mem_addr_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        error_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [31:0]          LINE_MASK = ~((32'd1 << LINE_OFFSET_W) - 32'd1);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX   = '1;
    localparam logic [TIMEOUT_W-1:0] CNT_ONE   = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic                 flush_q, flush_d;
    logic                 wb_q, wb_d;
    logic                 inv_q, inv_d;
    logic [31:0]          addr_q, addr_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    // opcode_valid_i is the only qualifier that can start an operation.
    logic capture_w;
    assign capture_w = opcode_valid_i & (cmo_flush_i | cmo_writeback_i | cmo_invalidate_i);

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            flush_q <= 1'b0;
            wb_q    <= 1'b0;
            inv_q   <= 1'b0;
            addr_q  <= 32'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            wb_q    <= wb_d;
            inv_q   <= inv_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        wb_d    = wb_q;
        inv_d   = inv_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (capture_w) begin
                    state_d = ST_REQ;
                    // Priority flush > writeback > invalidate; one strobe only.
                    flush_d = cmo_flush_i;
                    wb_d    = ~cmo_flush_i & cmo_writeback_i;
                    inv_d   = ~cmo_flush_i & ~cmo_writeback_i & cmo_invalidate_i;
                    addr_d  = cmo_addr_i & LINE_MASK;
                    err_d   = 1'b0;
                end
            end
            ST_REQ: begin
                // Acks before the accept belong to nothing and are dropped.
                if (mem_accept_i) begin
                    flush_d = 1'b0;
                    wb_d    = 1'b0;
                    inv_d   = 1'b0;
                    if (mem_ack_i) begin
                        state_d = ST_DONE;
                        err_d   = mem_error_i;
                    end else begin
                        state_d = ST_WAIT_ACK;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WAIT_ACK: begin
                // A real ack in the final timeout cycle takes precedence.
                if (mem_ack_i) begin
                    state_d = ST_DONE;
                    err_d   = mem_error_i;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_flush_o      = flush_q;
    assign mem_writeback_o  = wb_q;
    assign mem_invalidate_o = inv_q;
    assign mem_addr_o       = addr_q;

    assign stall_o = (state_q == ST_REQ) | (state_q == ST_WAIT_ACK) |
                     ((state_q == ST_IDLE) & capture_w);
    assign done_o  = (state_q == ST_DONE);
    assign error_o = (state_q == ST_DONE) & err_q;

endmodule

// File: tb/tb_biriscv_lsu_cmo_ctrl.sv
// tb/tb_biriscv_lsu_cmo_ctrl.sv - directed self-checking bench for biriscv_lsu_cmo_ctrl

module tb_biriscv_lsu_cmo_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        opcode_valid_i;
    logic        cmo_flush_i;
    logic        cmo_writeback_i;
    logic        cmo_invalidate_i;
    logic [31:0] cmo_addr_i;
    logic        mem_accept_i;
    logic        mem_ack_i;
    logic        mem_error_i;
    logic        mem_flush_o;
    logic        mem_writeback_o;
    logic        mem_invalidate_o;
    logic [31:0] mem_addr_o;
    logic        stall_o;
    logic        done_o;
    logic        error_o;

    int vecs = 0;
    int errs = 0;
    int n;

    biriscv_lsu_cmo_ctrl #(.LINE_OFFSET_W(5), .TIMEOUT_W(8)) dut (
        .clk             (clk),
        .rst_i           (rst_i),
        .opcode_valid_i  (opcode_valid_i),
        .cmo_flush_i     (cmo_flush_i),
        .cmo_writeback_i (cmo_writeback_i),
        .cmo_invalidate_i(cmo_invalidate_i),
        .cmo_addr_i      (cmo_addr_i),
        .mem_accept_i    (mem_accept_i),
        .mem_ack_i       (mem_ack_i),
        .mem_error_i     (mem_error_i),
        .mem_flush_o     (mem_flush_o),
        .mem_writeback_o (mem_writeback_o),
        .mem_invalidate_o(mem_invalidate_o),
        .mem_addr_o      (mem_addr_o),
        .stall_o         (stall_o),
        .done_o          (done_o),
        .error_o         (error_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        opcode_valid_i   = 1'b0;
        cmo_flush_i      = 1'b0;
        cmo_writeback_i  = 1'b0;
        cmo_invalidate_i = 1'b0;
        mem_accept_i     = 1'b0;
        mem_ack_i        = 1'b0;
        mem_error_i      = 1'b0;
    endtask

    // {flush, writeback, invalidate, stall, done, error}
    function automatic logic [31:0] outs();
        return {26'd0, mem_flush_o, mem_writeback_o, mem_invalidate_o, stall_o, done_o, error_o};
    endfunction

    // Capture an op, get it accepted without ack, leave the DUT in its first WAIT_ACK cycle.
    task automatic enter_wait(input logic [31:0] addr);
        cmo_invalidate_i = 1'b1;
        opcode_valid_i   = 1'b1;
        cmo_addr_i       = addr;
        step();
        idle_inputs();
        mem_accept_i = 1'b1;
        #1;
        step();
        mem_accept_i = 1'b0;
        #1;
    endtask

    initial begin
        idle_inputs();
        cmo_addr_i = 32'd0;
        rst_i      = 1'b1;
        #2;
        check("reset_outs", outs(), 32'h0);
        check("reset_addr", mem_addr_o, 32'h0);
        step();
        step();
        rst_i = 1'b0;

        // Gating: no opcode_valid -> nothing happens for 10 cycles.
        cmo_writeback_i = 1'b1;
        mem_accept_i    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("gate_outs", outs(), 32'h0);
            step();
        end
        idle_inputs();

        // Writeback, accept at cycle 3, ack at cycle 5, done at cycle 6.
        opcode_valid_i  = 1'b1;
        cmo_writeback_i = 1'b1;
        cmo_addr_i      = 32'h8000_1234;
        #1;
        check("wb_c0_stall", outs(), 32'b000100);
        step();
        idle_inputs();
        #1;
        check("wb_c1_outs", outs(), 32'b010100);
        check("wb_c1_addr", mem_addr_o, 32'h8000_1220);
        step();
        mem_ack_i = 1'b1;       // ack without accept must be ignored
        #1;
        check("wb_c2_outs", outs(), 32'b010100);
        step();
        mem_ack_i        = 1'b0;
        mem_accept_i     = 1'b1;
        opcode_valid_i   = 1'b1; // new request while busy must be ignored
        cmo_flush_i      = 1'b1;
        #1;
        check("wb_c3_outs", outs(), 32'b010100);
        check("wb_c3_addr", mem_addr_o, 32'h8000_1220);
        step();
        idle_inputs();
        #1;
        check("wb_c4_outs", outs(), 32'b000100);
        step();
        mem_ack_i = 1'b1;
        #1;
        check("wb_c5_outs", outs(), 32'b000100);
        step();
        idle_inputs();
        #1;
        check("wb_c6_done", outs(), 32'b000010);
        step();
        check("wb_c7_idle", outs(), 32'h0);

        // Flush + invalidate: flush wins, accept+ack same cycle -> done at cycle 2.
        opcode_valid_i   = 1'b1;
        cmo_flush_i      = 1'b1;
        cmo_invalidate_i = 1'b1;
        cmo_addr_i       = 32'h0000_003F;
        step();
        idle_inputs();
        mem_accept_i = 1'b1;
        mem_ack_i    = 1'b1;
        #1;
        check("fl_c1_outs", outs(), 32'b100100);
        check("fl_c1_addr", mem_addr_o, 32'h0000_0020);
        step();
        idle_inputs();
        #1;
        check("fl_c2_done", outs(), 32'b000010);
        step();
        check("fl_c3_idle", outs(), 32'h0);

        // Writeback + invalidate: writeback wins; direct ack with error.
        opcode_valid_i   = 1'b1;
        cmo_writeback_i  = 1'b1;
        cmo_invalidate_i = 1'b1;
        cmo_addr_i       = 32'h1234_567F;
        step();
        idle_inputs();
        mem_accept_i = 1'b1;
        mem_ack_i    = 1'b1;
        mem_error_i  = 1'b1;
        #1;
        check("wi_c1_outs", outs(), 32'b010100);
        check("wi_c1_addr", mem_addr_o, 32'h1234_5660);
        step();
        idle_inputs();
        #1;
        check("wi_c2_done_err", outs(), 32'b000011);
        step();

        // Timeout: 256 WAIT_ACK cycles without ack -> done with error.
        enter_wait(32'hFFFF_FFFF);
        check("to_addr", mem_addr_o, 32'hFFFF_FFE0);
        check("to_wait_outs", outs(), 32'b000100);
        n = 0;
        while (!done_o && n < 300) begin
            step();
            n++;
        end
        check("to_cycles", n, 256);
        check("to_done_err", outs(), 32'b000011);
        step();
        check("to_idle", outs(), 32'h0);

        // Ack arriving in the last timeout cycle wins, no error.
        enter_wait(32'h0000_0040);
        for (int i = 0; i < 255; i++) step();
        check("tw_still_wait", outs(), 32'b000100);
        mem_ack_i = 1'b1;
        step();
        idle_inputs();
        #1;
        check("tw_done_ok", outs(), 32'b000010);
        step();

        // Ack with error during WAIT_ACK.
        enter_wait(32'h0000_0080);
        step();
        step();
        mem_ack_i   = 1'b1;
        mem_error_i = 1'b1;
        step();
        idle_inputs();
        #1;
        check("we_done_err", outs(), 32'b000011);
        step();

        // Reset in WAIT_ACK abandons the op; stray ack afterwards is ignored.
        enter_wait(32'h0000_00C0);
        step();
        #2;
        rst_i = 1'b1;
        #1;
        check("rw_async_outs", outs(), 32'h0);
        check("rw_async_addr", mem_addr_o, 32'h0);
        step();
        rst_i     = 1'b0;
        mem_ack_i = 1'b1;
        step();
        check("rw_stray_ack", outs(), 32'h0);
        step();
        mem_ack_i = 1'b0;
        check("rw_stray_ack2", outs(), 32'h0);
        opcode_valid_i  = 1'b1;
        cmo_writeback_i = 1'b1;
        cmo_addr_i      = 32'h0000_0100;
        #1;
        check("rw_cap_stall", outs(), 32'b000100);
        step();
        idle_inputs();
        mem_accept_i = 1'b1;
        mem_ack_i    = 1'b1;
        #1;
        check("rw_c1_outs", outs(), 32'b010100);
        check("rw_c1_addr", mem_addr_o, 32'h0000_0100);
        step();
        idle_inputs();
        #1;
        check("rw_c2_done", outs(), 32'b000010);
        step();
        check("rw_c3_idle", outs(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
